mux_scheduler: RTL
==================

Name: mux_scheduler

Overview:
- Sequences the 16-bit channel multiplexer feeding the serial link.
- At a programmable frame period, it walks the enabled channels in order. For each channel it drives the selector and a clean data_lock pulse, captures the multiplexer output, and hands the word to the serial transmitter over a start/busy handshake.
- Flags frames that cannot start because the previous frame has not finished.

Parameters:
- NUM_CH, 2, number of multiplexer channels scheduled (1..256).
- PERIOD, 1000, clocks between frame requests (>= 2).
- LOCK_LEN, 2, cycles data_lock is held high per channel (>= 1).
- SEL_W, 8, selector width.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  1 = period timer runs and frames are issued.
- ch_mask  in  NUM_CH  bit i = 1 means channel i is included in the frame.
- clr_ovr  in  1  one-cycle pulse; clears overrun.
- selector  out  SEL_W  channel index to the multiplexer.
- data_lock  out  1  capture strobe to the multiplexer.
- mux_data  in  16  registered multiplexer output.
- tx_data  out  16  word presented to the transmitter.
- tx_start  out  1  one-cycle transmit request.
- tx_busy  in  1  transmitter busy; rises the cycle after tx_start.
- frame_done  out  1  one-cycle pulse at end of frame.
- overrun  out  1  sticky; a frame request was dropped.

Behaviour:
- Reset values: all outputs 0. FSM is in IDLE, period counter 0, channel index 0.
- Period timer:
  - Counts 0..PERIOD-1 while enable=1; holds at 0 while enable=0.
  - At terminal count it raises a one-cycle frame_req.
- frame_req handling:
  - In IDLE, frame_req starts a frame.
  - In any other state, frame_req sets overrun and is dropped.
  - If clr_ovr and a dropping frame_req occur in the same cycle, set wins.
- FSM states: IDLE, SELECT, LOCK, CAPTURE, SEND, WAIT_TX, NEXT.
- IDLE -> SELECT on frame_req.
  - The channel index loads the first set bit of ch_mask.
  - If ch_mask is all zero, go directly to NEXT-terminal: pulse frame_done and return to IDLE. No tx_start is issued.
- SELECT (1 cycle): selector <= channel index; data_lock = 0. This guarantees a low level before each rising edge of data_lock.
- LOCK (LOCK_LEN cycles): data_lock = 1. The multiplexer captures on the first LOCK edge, and mux_data is valid from the second LOCK cycle onward.
- CAPTURE (1 cycle): data_lock = 0; tx_data <= mux_data.
- SEND:
  - Waits while tx_busy=1.
  - When tx_busy=0, asserts tx_start for exactly one cycle, then -> WAIT_TX.
- WAIT_TX:
  - Ignores tx_busy in the first cycle (guard).
  - Afterwards, exits to NEXT when tx_busy=0.
- NEXT:
  - Advances to the next set bit of ch_mask above the current index and goes to SELECT.
  - If none remain: frame_done=1 for one cycle, selector returns to 0, go to IDLE.
- ch_mask is sampled once per channel advance. Changes mid-frame affect only channels not yet reached.
- enable dropping mid-frame: the current frame completes; no new requests are issued.
- Minimum per-channel latency: 1 + LOCK_LEN + 1 + 1 + tx time cycles.
- Asynchronous reset assertion mid-frame:
  - All state clears immediately.
  - tx_start and data_lock drop without completing.

Optional Feature:
- MUX_SCHED_HEADER_EN defined:
  - Each frame begins with a header word {8'hA5, frame_cnt[7:0]} sent through SEND/WAIT_TX before the first channel. There is no selector or data_lock activity for the header.
  - frame_cnt increments at each frame_done and wraps 255 -> 0; it is reset to 0.
  - With all channels masked, the header alone is sent.
- Undefined: no header and no frame counter logic.

Decomposition:
- Package mux_sched_pkg:
  - FSM state encoding.
  - HEADER_SYNC = 8'hA5.
  - Default PERIOD and LOCK_LEN constants.
- Natural sub-module: mux_sched_timer, containing the period counter and frame_req generation.
- The next-set-bit search is kept in the main module.

Test Plan:
- PERIOD=20, NUM_CH=2, ch_mask=2'b11, transmitter busy 5 cycles, data_0=16'h1234, data_1=16'hBEEF:
  - tx_data sequence is 1234, BEEF.
  - selector goes 0 then 1.
  - data_lock high 2 cycles each, low in between.
  - One frame_done per frame.
  - overrun stays 0.
- ch_mask=2'b10: only channel 1 is sent (selector never 0 during LOCK). ch_mask=2'b00: frame_done pulses with no tx_start.
- Transmitter busy 30 cycles with PERIOD=20: overrun sets on the second request. A clr_ovr pulse clears it, and the next dropped request sets it again.
- tx_busy held high before SEND: tx_start stays low until tx_busy falls, then pulses exactly once.
- Reset asserted during LOCK of channel 1: all outputs 0 in the same cycle. After release with enable=1, the next frame restarts at channel 0.
- With MUX_SCHED_HEADER_EN, three frames: first words are A500, A501, A502, each followed by channel data.

Source files
------------

// File: rtl/mux_sched_pkg.sv
// Shared definitions for the channel-multiplexer scheduler.
package mux_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SELECT  = 3'd1,
    ST_LOCK    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_SEND    = 3'd4,
    ST_WAIT_TX = 3'd5,
    ST_NEXT    = 3'd6
  } sched_state_t;

  // Sync byte carried in the upper half of the optional frame header word.
  localparam logic [7:0]  HEADER_SYNC  = 8'hA5;

  localparam int unsigned DEF_PERIOD   = 1000;
  localparam int unsigned DEF_LOCK_LEN = 2;

endpackage

// File: rtl/mux_sched_timer.sv
// Frame period timer: counts 0..PERIOD-1 while enabled and flags the
// terminal count as a one-cycle frame request.
module mux_sched_timer
  import mux_sched_pkg::*;
#(
  parameter int unsigned PERIOD = DEF_PERIOD
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_enable,
  output logic o_frame_req
);

  localparam int unsigned CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  logic [CNT_W-1:0] r_cnt;
  logic             w_tc;

  assign w_tc = (r_cnt == CNT_W'(PERIOD - 1));

  // Period counter; parked at zero whenever the timer is disabled.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (!i_enable) begin
      r_cnt <= '0;
    end else if (w_tc) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_frame_req = i_enable & w_tc;

endmodule

// File: rtl/mux_scheduler.sv
// Channel multiplexer scheduler: per frame walks the enabled channels,
// strobes the multiplexer, captures its output and hands each word to the
// serial transmitter. Optional build macro MUX_SCHED_HEADER_EN prefixes
// every frame with a {8'hA5, frame_cnt} header word.
module mux_scheduler
  import mux_sched_pkg::*;
#(
  parameter int unsigned NUM_CH   = 2,
  parameter int unsigned PERIOD   = DEF_PERIOD,
  parameter int unsigned LOCK_LEN = DEF_LOCK_LEN,
  parameter int unsigned SEL_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [NUM_CH-1:0] ch_mask,
  input  logic              clr_ovr,
  output logic [SEL_W-1:0]  selector,
  output logic              data_lock,
  input  logic [15:0]       mux_data,
  output logic [15:0]       tx_data,
  output logic              tx_start,
  input  logic              tx_busy,
  output logic              frame_done,
  output logic              overrun
);

  localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned IDX_W = CH_W + 1;
  localparam int unsigned LC_W  = (LOCK_LEN > 1) ? $clog2(LOCK_LEN) : 1;

  // Lowest set bit of m at or above s; NUM_CH when there is none.
  function automatic logic [IDX_W-1:0] find_from(input logic [NUM_CH-1:0] m,
                                                 input logic [IDX_W-1:0]  s);
    logic [IDX_W-1:0] res;
    res = IDX_W'(NUM_CH);
    for (int unsigned i = NUM_CH; i > 0; i--) begin
      if (m[i-1] && (IDX_W'(i - 1) >= s)) begin
        res = IDX_W'(i - 1);
      end
    end
    return res;
  endfunction

  sched_state_t      r_state, w_state_nxt;
  logic [CH_W-1:0]   r_ch, w_ch_nxt;
  logic [IDX_W-1:0]  r_nstart, w_nstart_nxt;
  logic [LC_W-1:0]   r_lock_cnt, w_lock_cnt_nxt;
  logic              r_guard, w_guard_nxt;
  logic [SEL_W-1:0]  r_sel, w_sel_nxt;
  logic              r_data_lock;
  logic [15:0]       r_tx_data, w_tx_data_nxt;
  logic              r_tx_start, w_tx_start_nxt;
  logic              r_frame_done, w_frame_done_nxt;
  logic              r_overrun;
  logic              w_frame_req;
  logic [IDX_W-1:0]  w_search_start;
  logic [IDX_W-1:0]  w_found;
  logic              w_none;
  logic [IDX_W-1:0]  w_ch_inc;
`ifdef MUX_SCHED_HEADER_EN
  logic              r_hdr, w_hdr_nxt;
  logic [7:0]        r_frame_cnt;
`endif

  mux_sched_timer #(
    .PERIOD (PERIOD)
  ) u_timer (
    .i_clk       (clk),
    .i_rst_n     (reset),
    .i_enable    (enable),
    .o_frame_req (w_frame_req)
  );

  assign w_search_start = (r_state == ST_IDLE) ? '0 : r_nstart;
  assign w_found        = find_from(ch_mask, w_search_start);
  assign w_none         = (w_found == IDX_W'(NUM_CH));
  assign w_ch_inc       = {1'b0, r_ch} + IDX_W'(1);

  // Next-state and next-output decode for the frame sequencer.
  always_comb begin
    w_state_nxt      = r_state;
    w_ch_nxt         = r_ch;
    w_nstart_nxt     = r_nstart;
    w_lock_cnt_nxt   = r_lock_cnt;
    w_guard_nxt      = r_guard;
    w_sel_nxt        = r_sel;
    w_tx_data_nxt    = r_tx_data;
    w_tx_start_nxt   = 1'b0;
    w_frame_done_nxt = 1'b0;
`ifdef MUX_SCHED_HEADER_EN
    w_hdr_nxt        = r_hdr;
`endif
    case (r_state)
      ST_IDLE: begin
        if (w_frame_req) begin
`ifdef MUX_SCHED_HEADER_EN
          w_hdr_nxt     = 1'b1;
          w_tx_data_nxt = {HEADER_SYNC, r_frame_cnt};
          w_state_nxt   = ST_SEND;
`else
          if (w_none) begin
            // Empty mask: NEXT searches from NUM_CH, so it ends the frame at once.
            w_nstart_nxt = IDX_W'(NUM_CH);
            w_state_nxt  = ST_NEXT;
          end else begin
            w_ch_nxt    = w_found[CH_W-1:0];
            w_state_nxt = ST_SELECT;
          end
`endif
        end
      end
      ST_SELECT: begin
        w_sel_nxt      = SEL_W'(r_ch);
        w_lock_cnt_nxt = '0;
        w_state_nxt    = ST_LOCK;
      end
      ST_LOCK: begin
        if (r_lock_cnt == LC_W'(LOCK_LEN - 1)) begin
          w_state_nxt = ST_CAPTURE;
        end else begin
          w_lock_cnt_nxt = r_lock_cnt + 1'b1;
        end
      end
      ST_CAPTURE: begin
        w_tx_data_nxt = mux_data;
        w_state_nxt   = ST_SEND;
      end
      ST_SEND: begin
        if (!tx_busy) begin
          w_tx_start_nxt = 1'b1;
          w_guard_nxt    = 1'b1;
          w_state_nxt    = ST_WAIT_TX;
        end
      end
      ST_WAIT_TX: begin
        if (r_guard) begin
          w_guard_nxt = 1'b0;
        end else if (!tx_busy) begin
`ifdef MUX_SCHED_HEADER_EN
          w_nstart_nxt = r_hdr ? '0 : w_ch_inc;
          w_hdr_nxt    = 1'b0;
`else
          w_nstart_nxt = w_ch_inc;
`endif
          w_state_nxt  = ST_NEXT;
        end
      end
      ST_NEXT: begin
        if (w_none) begin
          w_frame_done_nxt = 1'b1;
          w_sel_nxt        = '0;
          w_ch_nxt         = '0;
          w_state_nxt      = ST_IDLE;
        end else begin
          w_ch_nxt    = w_found[CH_W-1:0];
          w_state_nxt = ST_SELECT;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; data_lock is registered from the next
  // state so it is high exactly for the LOCK cycles and glitch-free.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_ch         <= '0;
      r_nstart     <= '0;
      r_lock_cnt   <= '0;
      r_guard      <= 1'b0;
      r_sel        <= '0;
      r_data_lock  <= 1'b0;
      r_tx_data    <= '0;
      r_tx_start   <= 1'b0;
      r_frame_done <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_ch         <= w_ch_nxt;
      r_nstart     <= w_nstart_nxt;
      r_lock_cnt   <= w_lock_cnt_nxt;
      r_guard      <= w_guard_nxt;
      r_sel        <= w_sel_nxt;
      r_data_lock  <= (w_state_nxt == ST_LOCK);
      r_tx_data    <= w_tx_data_nxt;
      r_tx_start   <= w_tx_start_nxt;
      r_frame_done <= w_frame_done_nxt;
      if (w_frame_req && (r_state != ST_IDLE)) begin
        r_overrun <= 1'b1;
      end else if (clr_ovr) begin
        r_overrun <= 1'b0;
      end
    end
  end

`ifdef MUX_SCHED_HEADER_EN
  // Header bookkeeping: header-in-flight flag and wrapping frame counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hdr       <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_hdr <= w_hdr_nxt;
      if (w_frame_done_nxt) begin
        r_frame_cnt <= r_frame_cnt + 1'b1;
      end
    end
  end
`endif

  assign selector   = r_sel;
  assign data_lock  = r_data_lock;
  assign tx_data    = r_tx_data;
  assign tx_start   = r_tx_start;
  assign frame_done = r_frame_done;
  assign overrun    = r_overrun;

endmodule
